// File: rtl/pnctrl.sv
// Buffer-token controller: three circular token queues (snooper, CPU, forwarder) over N_BUF buffers.
// Optional macro PNCTRL_FAST_HANDOFF_EN lets a busy agent take the next buffer while finishing the current one.
module pnctrl #(
    parameter  int N_BUF = 3,
    localparam int IDX_W = (N_BUF <= 2) ? 1 : $clog2(N_BUF),
    localparam int CNT_W = $clog2(N_BUF + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               A_done,
    output logic               A_done_ack,
    output logic               rdy_for_A,
    input  logic               rdy_for_A_ack,
    input  logic               B_acc,
    input  logic               B_rej,
    output logic               B_done_ack,
    output logic               rdy_for_B,
    input  logic               rdy_for_B_ack,
    input  logic               C_done,
    output logic               C_done_ack,
    output logic               rdy_for_C,
    input  logic               rdy_for_C_ack,
    output logic [IDX_W:0]     sn_sel,
    output logic [IDX_W:0]     cpu_sel,
    output logic [IDX_W:0]     fwd_sel,
    output logic [2*N_BUF-1:0] owner,
    output logic [CNT_W-1:0]   sn_cnt,
    output logic [CNT_W-1:0]   cpu_cnt,
    output logic [CNT_W-1:0]   fwd_cnt
);
    localparam int PW = IDX_W + 2;

    typedef enum logic {NOT_STARTED = 1'b0, STARTED = 1'b1} state_t;

    // Queue index 0 = snooper (A), 1 = CPU (B), 2 = forwarder (C)
    logic [IDX_W-1:0] head_tok [3];
    logic [CNT_W-1:0] cnt      [3];
    logic [IDX_W-1:0] enq0_val [3];
    logic [IDX_W-1:0] enq1_val [3];
    logic [2:0]       deq, enq0_en, enq1_en;
    logic [2:0]       conn, rdy, dack, rdy_ack, done_in;
    logic             qa, qb, qc, acc, rej;

    function automatic logic [IDX_W-1:0] wrap(input logic [PW-1:0] s);
        logic [PW-1:0] r;
        r = (s >= PW'(N_BUF)) ? s - PW'(N_BUF) : s;
        return r[IDX_W-1:0];
    endfunction

    assign done_in = {C_done, B_acc | B_rej, A_done};
    assign rdy_ack = {rdy_for_C_ack, rdy_for_B_ack, rdy_for_A_ack};

    assign qa  = A_done & dack[0];
    assign qb  = (B_acc | B_rej) & dack[1];
    assign acc = qb & B_acc;
    assign rej = qb & ~B_acc;
    assign qc  = C_done & dack[2];

    // Into the snooper queue the forwarder token lands before the rejected CPU token
    always_comb begin
        deq         = {qc, qb, qa};
        enq0_en     = {acc, qa, qc | rej};
        enq1_en     = {1'b0, 1'b0, qc & rej};
        enq0_val[0] = qc ? head_tok[2] : head_tok[1];
        enq1_val[0] = head_tok[1];
        enq0_val[1] = head_tok[0];
        enq1_val[1] = '0;
        enq0_val[2] = head_tok[1];
        enq1_val[2] = '0;
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_queue
        logic [IDX_W-1:0] mem [N_BUF];
        logic [IDX_W-1:0] head_reg;
        logic [CNT_W-1:0] cnt_reg;
        logic [IDX_W-1:0] tail0, tail1;

        // A full queue writes its tail over the head slot only when that head is leaving
        assign tail0 = wrap(PW'(head_reg) + PW'(cnt_reg));
        assign tail1 = wrap(PW'(head_reg) + PW'(cnt_reg) + PW'(enq0_en[gi]));

        always_ff @(posedge clk) begin
            if (rst) begin
                head_reg <= '0;
                cnt_reg  <= (gi == 0) ? CNT_W'(N_BUF) : '0;
                for (int i = 0; i < N_BUF; i++)
                    mem[i] <= (gi == 0) ? IDX_W'(i) : '0;
            end else begin
                if (enq0_en[gi])
                    mem[tail0] <= enq0_val[gi];
                if (enq1_en[gi])
                    mem[tail1] <= enq1_val[gi];
                if (deq[gi])
                    head_reg <= wrap(PW'(head_reg) + PW'(1));
                cnt_reg <= cnt_reg + CNT_W'(enq0_en[gi]) + CNT_W'(enq1_en[gi]) - CNT_W'(deq[gi]);
            end
        end

        assign head_tok[gi] = mem[head_reg];
        assign cnt[gi]      = cnt_reg;
        assign conn[gi]     = (cnt_reg != '0);
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_fsm
        state_t state_reg, state_next;
        logic   rdy_loc, dack_loc;

        always_ff @(posedge clk) begin
            if (rst)
                state_reg <= NOT_STARTED;
            else
                state_reg <= state_next;
        end

        always_comb begin
            state_next = state_reg;
            case (state_reg)
                NOT_STARTED: if (rdy_loc && rdy_ack[gi]) state_next = STARTED;
                STARTED: begin
`ifdef PNCTRL_FAST_HANDOFF_EN
                    if (done_in[gi] && !(rdy_loc && rdy_ack[gi])) state_next = NOT_STARTED;
`else
                    if (done_in[gi]) state_next = NOT_STARTED;
`endif
                end
                default: state_next = NOT_STARTED;
            endcase
        end

        always_comb begin
            rdy_loc  = 1'b0;
            dack_loc = 1'b0;
            if (state_reg == NOT_STARTED) begin
                rdy_loc = conn[gi];
            end else begin
                dack_loc = 1'b1;
`ifdef PNCTRL_FAST_HANDOFF_EN
                rdy_loc = (cnt[gi] >= CNT_W'(2));
`endif
            end
        end

        assign rdy[gi]  = rdy_loc;
        assign dack[gi] = dack_loc;
    end

    assign rdy_for_A  = rdy[0];
    assign rdy_for_B  = rdy[1];
    assign rdy_for_C  = rdy[2];
    assign A_done_ack = dack[0];
    assign B_done_ack = dack[1];
    assign C_done_ack = dack[2];

    assign sn_sel  = {conn[0], conn[0] ? head_tok[0] : '0};
    assign cpu_sel = {conn[1], conn[1] ? head_tok[1] : '0};
    assign fwd_sel = {conn[2], conn[2] ? head_tok[2] : '0};
    assign sn_cnt  = cnt[0];
    assign cpu_cnt = cnt[1];
    assign fwd_cnt = cnt[2];

    // Tokens are unique, so at most one head can name a given buffer
    always_comb begin
        owner = '0;
        for (int i = 0; i < N_BUF; i++) begin
            if (conn[0] && head_tok[0] == IDX_W'(i))
                owner[2*i +: 2] = 2'd1;
            else if (conn[1] && head_tok[1] == IDX_W'(i))
                owner[2*i +: 2] = 2'd2;
            else if (conn[2] && head_tok[2] == IDX_W'(i))
                owner[2*i +: 2] = 2'd3;
        end
    end
endmodule

// File: tb/tb_pnctrl.sv
// Scoreboard bench for pnctrl (N_BUF=4): a queue-based reference model predicts every cycle's outputs.
module tb_pnctrl;
    localparam int NB = 4;
    localparam int IW = 2;
    localparam int CW = 3;
`ifdef PNCTRL_FAST_HANDOFF_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, A_done, A_done_ack, rdy_for_A, rdy_for_A_ack;
    logic B_acc, B_rej, B_done_ack, rdy_for_B, rdy_for_B_ack;
    logic C_done, C_done_ack, rdy_for_C, rdy_for_C_ack;
    logic [IW:0]     sn_sel, cpu_sel, fwd_sel;
    logic [2*NB-1:0] owner;
    logic [CW-1:0]   sn_cnt, cpu_cnt, fwd_cnt;

    pnctrl #(.N_BUF(NB)) dut (
        .clk(clk), .rst(rst),
        .A_done(A_done), .A_done_ack(A_done_ack), .rdy_for_A(rdy_for_A), .rdy_for_A_ack(rdy_for_A_ack),
        .B_acc(B_acc), .B_rej(B_rej), .B_done_ack(B_done_ack), .rdy_for_B(rdy_for_B), .rdy_for_B_ack(rdy_for_B_ack),
        .C_done(C_done), .C_done_ack(C_done_ack), .rdy_for_C(rdy_for_C), .rdy_for_C_ack(rdy_for_C_ack),
        .sn_sel(sn_sel), .cpu_sel(cpu_sel), .fwd_sel(fwd_sel), .owner(owner),
        .sn_cnt(sn_cnt), .cpu_cnt(cpu_cnt), .fwd_cnt(fwd_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        int sn_sel, cpu_sel, fwd_sel, owner, sn_cnt, cpu_cnt, fwd_cnt, rdy, ack;
    } exp_t;
    exp_t sb[$];

    // Reference model: token queues plus one started flag per agent
    int sq[$], cq[$], fq[$];
    bit st[3];

    function automatic void model_reset();
        sq.delete(); cq.delete(); fq.delete();
        for (int i = 0; i < NB; i++) sq.push_back(i);
        for (int k = 0; k < 3; k++) st[k] = 1'b0;
    endfunction

    function automatic void model_lens(output int lens[3], output int heads[3]);
        lens[0] = sq.size(); lens[1] = cq.size(); lens[2] = fq.size();
        heads[0] = (lens[0] > 0) ? sq[0] : 0;
        heads[1] = (lens[1] > 0) ? cq[0] : 0;
        heads[2] = (lens[2] > 0) ? fq[0] : 0;
    endfunction

    function automatic bit model_rdy(int k, int len);
        if (st[k]) return FAST && (len >= 2);
        return len > 0;
    endfunction

    function automatic exp_t snap();
        exp_t e;
        int lens[3], heads[3], sels[3];
        int own = 0, r = 0, a = 0;
        model_lens(lens, heads);
        for (int k = 0; k < 3; k++) begin
            sels[k] = (lens[k] > 0) ? ((1 << IW) | heads[k]) : 0;
            if (lens[k] > 0) own = own | ((k + 1) << (2 * heads[k]));
            if (model_rdy(k, lens[k])) r = r | (1 << k);
            if (st[k]) a = a | (1 << k);
        end
        e.sn_sel = sels[0]; e.cpu_sel = sels[1]; e.fwd_sel = sels[2];
        e.owner = own; e.sn_cnt = lens[0]; e.cpu_cnt = lens[1]; e.fwd_cnt = lens[2];
        e.rdy = r; e.ack = a;
        return e;
    endfunction

    task automatic step(input bit r, input bit ad, input bit ar, input bit ba, input bit br,
                        input bit bk, input bit cd, input bit ck);
        exp_t e;
        int lens[3], heads[3];
        bit rd[3], dn[3], rk[3];
        bit qa, qb, qc, acc, rej;
        int ta = 0, tb = 0, tc = 0;
        rst = r; A_done = ad; rdy_for_A_ack = ar; B_acc = ba; B_rej = br;
        rdy_for_B_ack = bk; C_done = cd; rdy_for_C_ack = ck;
        if (r) begin
            model_reset();
        end else begin
            model_lens(lens, heads);
            for (int k = 0; k < 3; k++) rd[k] = model_rdy(k, lens[k]);
            dn[0] = ad; dn[1] = ba | br; dn[2] = cd;
            rk[0] = ar; rk[1] = bk; rk[2] = ck;
            qa = ad && st[0]; qb = (ba || br) && st[1]; qc = cd && st[2];
            acc = qb && ba; rej = qb && !ba;
            for (int k = 0; k < 3; k++) begin
                if (!st[k]) begin
                    if (rd[k] && rk[k]) st[k] = 1'b1;
                end else if (dn[k]) begin
                    st[k] = FAST && rd[k] && rk[k];
                end
            end
            if (qa) ta = sq.pop_front();
            if (qb) tb = cq.pop_front();
            if (qc) tc = fq.pop_front();
            if (qa)  cq.push_back(ta);
            if (acc) fq.push_back(tb);
            if (qc)  sq.push_back(tc);
            if (rej) sq.push_back(tb);
        end
        sb.push_back(snap());
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_eq("sn_sel",  int'(sn_sel),  e.sn_sel);
        check_eq("cpu_sel", int'(cpu_sel), e.cpu_sel);
        check_eq("fwd_sel", int'(fwd_sel), e.fwd_sel);
        check_eq("owner",   int'(owner),   e.owner);
        check_eq("sn_cnt",  int'(sn_cnt),  e.sn_cnt);
        check_eq("cpu_cnt", int'(cpu_cnt), e.cpu_cnt);
        check_eq("fwd_cnt", int'(fwd_cnt), e.fwd_cnt);
        check_eq("rdy_cba", int'({rdy_for_C, rdy_for_B, rdy_for_A}), e.rdy);
        check_eq("ack_cba", int'({C_done_ack, B_done_ack, A_done_ack}), e.ack);
    endtask

    // Shorthands: step(rst, A_done, A_ack, B_acc, B_rej, B_ack, C_done, C_ack)
    task automatic idle();   step(0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic a_take(); step(0, 0, 1, 0, 0, 0, 0, 0); endtask
    task automatic a_fin();  step(0, 1, 0, 0, 0, 0, 0, 0); endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check_eq("rst_sn_sel", int'(sn_sel), 4);
        check_eq("rst_owner", int'(owner), 1);
        check_eq("rst_sn_cnt", int'(sn_cnt), NB);
        check_eq("rst_rdy_a", int'(rdy_for_A), 1);

        // Snooper takes buffer 0 and hands it to the CPU
        a_take();
        idle();
        a_fin();
        check_eq("a2b_sn_sel", int'(sn_sel), 5);
        check_eq("a2b_cpu_sel", int'(cpu_sel), 4);
        check_eq("a2b_owner0", int'(owner[1:0]), 2);
        check_eq("a2b_rdy_b", int'(rdy_for_B), 1);

        // Token 0 goes B -> C -> back to the sn tail: sn order 1,2,3,0
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        check_eq("rot_sn_sel", int'(sn_sel), 5);
        check_eq("rot_sn_cnt", int'(sn_cnt), NB);

        // Arrange fwd head 1 and cpu head 2, then reject and forward-done together
        a_take(); a_fin();
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        a_take(); a_fin();
        step(0, 0, 0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 1, 0, 1, 0);
        check_eq("dual_sn_cnt", int'(sn_cnt), NB);
        check_eq("dual_cpu_cnt", int'(cpu_cnt), 0);
        check_eq("dual_fwd_cnt", int'(fwd_cnt), 0);
        // sn is now 3,0,1,2; after three snooper passes only buffer 2 remains
        repeat (3) begin a_take(); a_fin(); end
        check_eq("dual_order", int'(sn_sel), 6);

        // Done together with a take while a backlog exists
        step(1, 0, 0, 0, 0, 0, 0, 0);
        a_take();
        step(0, 1, 1, 0, 0, 0, 0, 0);
        check_eq("handoff_ack_a", int'(A_done_ack), FAST ? 1 : 0);

        // Reset while A and B hold buffers; the late A_done must be ignored
        step(1, 0, 0, 0, 0, 0, 0, 0);
        a_take(); a_fin();
        step(0, 0, 1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        check_eq("mid_rst_sn_cnt", int'(sn_cnt), NB);
        check_eq("mid_rst_ack_a", int'(A_done_ack), 0);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        check_eq("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pnctrl.md
Name: pnctrl

Overview:
- Parametrised buffer-token controller for the packet filter core. Generalises the fixed three-buffer ping/pang/pong scheme to N_BUF packet buffers.
- Three token queues (snooper A, CPU B, forwarder C) hold buffer indices. The block moves tokens between queues on handshaken done events.
- Produces per-agent buffer select and per-buffer owner codes, which drive the buffer muxes.

Parameters:
- N_BUF, 3, number of packet buffers; legal range 2..16.
- IDX_W, (N_BUF<=2 ? 1 : $clog2(N_BUF)), buffer index width; derived, not to be overridden.
- CNT_W, $clog2(N_BUF+1), width of occupancy counts; derived.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- A_done  in  1  snooper finished with its buffer
- A_done_ack  out  1  controller accepts A_done
- rdy_for_A  out  1  buffer available to snooper
- rdy_for_A_ack  in  1  snooper takes the buffer
- B_acc, B_rej  in  1 each  CPU accepts / rejects the packet; mutually exclusive
- B_done_ack  out  1  controller accepts B_acc or B_rej
- rdy_for_B  out  1  buffer available to CPU
- rdy_for_B_ack  in  1  CPU takes the buffer
- C_done  in  1  forwarder finished with its buffer
- C_done_ack  out  1  controller accepts C_done
- rdy_for_C  out  1  buffer available to forwarder
- rdy_for_C_ack  in  1  forwarder takes the buffer
- sn_sel, cpu_sel, fwd_sel  out  IDX_W+1 each  {valid, index} of the head token of each queue
- owner  out  2*N_BUF  per-buffer owner code, slice [2i+1:2i] for buffer i: 0 idle/queued, 1 snooper, 2 CPU, 3 forwarder
- sn_cnt, cpu_cnt, fwd_cnt  out  CNT_W each  queue occupancy

Behaviour:
- Queues: three circular FIFOs, each of depth N_BUF. Total tokens always equal N_BUF, so overflow is impossible.
- Reset state: the sn queue holds 0,1,...,N_BUF-1 in order (head = 0). The cpu and fwd queues are empty.
- Counts after reset: sn_cnt=N_BUF, cpu_cnt=0, fwd_cnt=0.
- Outputs after reset:
  - sn_sel={1,0}; cpu_sel=0; fwd_sel=0.
  - owner: buffer 0 = 1, all others 0.
  - All acks and rdys are 0 except rdy_for_A=1.
- Connected rule: X_connected = valid bit of the agent's sel. Agent X uses sn/cpu/fwd for A/B/C.
- Per-agent handshake FSM, states NOT_STARTED and STARTED:
  - In NOT_STARTED: rdy_for_X = X_connected; done_ack_X = 0. When rdy_for_X && rdy_ack, go to STARTED.
  - In STARTED: rdy_for_X = 0; done_ack_X = 1. When done && done_ack, go to NOT_STARTED.
  - A done input asserted in NOT_STARTED is ignored.
- Token moves, all on a qualified done (done && done_ack):
  - A_done: dequeue sn head and enqueue it to cpu.
  - B_acc: dequeue cpu head and enqueue it to fwd.
  - B_rej: dequeue cpu head and enqueue it to sn.
  - C_done: dequeue fwd head and enqueue it to sn.
- Latency:
  - A qualified done in cycle t updates sel, owner and counts in t+1.
  - rdy_for_X rises in t+1 if the queue is non-empty.
  - A token moved to an empty queue makes that queue's sel valid in t+1.
- Simultaneous events:
  - Any combination of A, B and C done events in the same cycle is legal and processed in one cycle.
  - B_rej and C_done together: the C token is enqueued to sn first, then the B token; tail advances by 2.
  - A queue may dequeue and enqueue in the same cycle. Count is unchanged, and the head is taken from the pre-dequeue contents.
  - B_acc and B_rej both high is illegal; B_acc takes priority.
- Empty queue: sel valid = 0 and owner shows no buffer for that agent. rdy_for_X stays 0 until a token arrives.
- Reset mid-operation: all FSMs return to NOT_STARTED and queues reload the reset contents in the next cycle. In-flight handshakes are discarded.
- Owner derivation: combinational from the three sels. A buffer not at any head reads 0.

Optional Feature:
- Macro: PNCTRL_FAST_HANDOFF_EN.
- Defined:
  - In STARTED, rdy_for_X = (queue count >= 2), asserted together with done_ack.
  - If done_sig and rdy_sig occur in the same cycle, the FSM stays in STARTED.
  - The agent is bound to the new head, visible at t+1. This saves one idle cycle per packet when a backlog exists.
- Undefined: rdy_for_X is 0 in STARTED, exactly as described in Behaviour.

Test Plan:
- Reset, N_BUF=3 -> sn_sel={1,0}, sn_cnt=3, owner=6'b000001, rdy_for_A=1, rdy_for_B=0, rdy_for_C=0.
- rdy_for_A_ack at t0, A_done at t2 -> t3: sn_sel={1,1}, cpu_sel={1,0}, cpu_cnt=1, rdy_for_B=1, owner[1:0]=2.
- Buffer 0 through A then B_acc, then C_done -> token 0 re-enters the sn queue tail. Order after a full rotation of N_BUF=4 is 1,2,3,0.
- B_rej and C_done in the same cycle, with cpu head 2 and fwd head 1 -> sn enqueue order 1 then 2; fwd_cnt and cpu_cnt each drop by 1.
- rst pulsed while A and B are STARTED -> next cycle matches the reset state; the late A_done is ignored.
- With PNCTRL_FAST_HANDOFF_EN and sn_cnt=3, done plus rdy_ack in the same cycle -> A stays STARTED and sn_sel advances by 1 with zero idle cycles. Without the macro, one idle cycle occurs.
